// File: rtl/hack_pkg.sv
// hack_pkg -- shared types for the Hack program counter slice.
//   HACK_WORD_W : native Hack word width
//   word_t      : one Hack word
//   pc_op_e     : command chosen each cycle by the program-counter priority encoder
package hack_pkg;

  localparam int HACK_WORD_W = 16;

  typedef logic [HACK_WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_RST
  } pc_op_e;

endpackage

// File: rtl/hack_pc_stack.sv
// hack_pc_stack -- WIDTH x DEPTH LIFO holding return addresses.
// Ports:
//   clk    in   rising-edge clock
//   clear  in   synchronous clear (empties the stack, contents discarded)
//   push   in   write din on top (ignored when full)
//   pop    in   discard top entry (ignored when empty; wins over push)
//   din    in   WIDTH  value to push
//   top    out  WIDTH  current top entry (don't-care when empty)
//   count  out  number of entries held
//   empty  out  count == 0
//   full   out  count == DEPTH
// DEPTH must be a power of two so the write pointer wraps naturally.
module hack_pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] top_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    below_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !pop && !full && !clear;

  // Slot for the next push, and the slot just beneath the current top
  // (the entry that becomes the new top after a pop).
  assign wr_ptr    = count_reg[AW-1:0];
  assign below_ptr = count_reg[AW-1:0] - AW'(2);

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (do_pop) begin
      count_next = count_reg - CW'(1);
    end else if (do_push) begin
      count_next = count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_reg <= count_next;
  end

  // Storage has no reset so it maps onto RAM. The top entry is kept in a
  // register refreshed by a registered array read, so a pop makes the next
  // return address visible immediately after the edge.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
      top_reg     <= din;
    end else if (do_pop) begin
      top_reg <= mem[below_ptr];
    end
  end

  assign top   = top_reg;
  assign count = count_reg;

endmodule

// File: rtl/hack_pc.sv
// hack_pc -- parametrised Hack program counter with optional return stack.
// Build option: define HACK_PC_STACK_EN to enable call/ret and the stack;
// without it call/ret are ignored, no storage exists, and the flags read
// empty=1 / full=0 / err=0. The port list is the same in both builds.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   inc          in   out <= out + 1
//   load         in   out <= in
//   call         in   push out+1, out <= in
//   ret          in   out <= popped return address
//   in           in   WIDTH load/call target
//   out          out  WIDTH current PC (ROM address)
//   stack_empty  out  stack holds no entries
//   stack_full   out  stack holds STACK_DEPTH entries
//   stack_err    out  sticky overflow/underflow flag, cleared only by rst
// Priority: rst > ret > call > load > inc > hold.
module hack_pc
  import hack_pkg::*;
#(
  parameter int               WIDTH       = HACK_WORD_W,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               STACK_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic             err_reg;
  logic             err_next;
  logic             push;
  logic             pop;
  logic             stk_empty;
  logic             stk_full;
  logic [WIDTH-1:0] stk_top;
  logic             call_en;
  logic             ret_en;

`ifdef HACK_PC_STACK_EN
  logic [$clog2(STACK_DEPTH):0] stk_count;

  assign call_en = call;
  assign ret_en  = ret;

  hack_pc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .clear (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_reg + WIDTH'(1)),
    .top   (stk_top),
    .count (stk_count),
    .empty (stk_empty),
    .full  (stk_full)
  );

  assign stack_empty = stk_empty;
  assign stack_full  = stk_full;
  assign stack_err   = err_reg;

  // The occupancy count is only needed through the empty/full decodes.
  logic unused_count;
  assign unused_count = ^stk_count;
`else
  // Stack disabled: call/ret never reach the encoder and the flags are
  // tied to their idle values.
  assign call_en   = 1'b0;
  assign ret_en    = 1'b0;
  assign stk_empty = 1'b1;
  assign stk_full  = 1'b0;
  assign stk_top   = '0;

  assign stack_empty = 1'b1;
  assign stack_full  = 1'b0;
  assign stack_err   = 1'b0;

  logic unused_nostack;
  assign unused_nostack = ^{call, ret, push, pop, err_reg} | (STACK_DEPTH < 2);
`endif

  // Priority encoder.
  always_comb begin
    op = OP_HOLD;
    if (rst) begin
      op = OP_RST;
    end else if (ret_en) begin
      op = OP_RET;
    end else if (call_en) begin
      op = OP_CALL;
    end else if (load) begin
      op = OP_LOAD;
    end else if (inc) begin
      op = OP_INC;
    end
  end

  // A blocked call (full) or ret (empty) still owns the cycle: nothing of
  // lower priority runs, the PC holds and the error flag latches.
  always_comb begin
    pc_next  = pc_reg;
    err_next = err_reg;
    push     = 1'b0;
    pop      = 1'b0;
    case (op)
      OP_RST: begin
        pc_next  = RESET_VAL;
        err_next = 1'b0;
      end
      OP_RET: begin
        if (stk_empty) begin
          err_next = 1'b1;
        end else begin
          pc_next = stk_top;
          pop     = 1'b1;
        end
      end
      OP_CALL: begin
        if (stk_full) begin
          err_next = 1'b1;
        end else begin
          pc_next = in;
          push    = 1'b1;
        end
      end
      OP_LOAD: pc_next = in;
      OP_INC:  pc_next = pc_reg + WIDTH'(1);
      default: pc_next = pc_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    pc_reg  <= pc_next;
    err_reg <= err_next;
  end

  assign out = pc_reg;

endmodule
